// File: rtl/colorizer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | colorizer_pkg: colour constants and default world palette          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package colorizer_pkg;

  // Colours are built 64 bits wide; callers size-cast to their COLOR_W.
  function automatic logic [63:0] ones_w(input int cw);
    logic [63:0] all1;
    all1 = '1;
    return (cw <= 0) ? 64'd0 : (all1 >> (64 - cw));
  endfunction

  function automatic logic [63:0] black(input int cw);
    return ones_w(cw) & 64'd0;
  endfunction

  function automatic logic [63:0] white(input int cw);
    return ones_w(cw);
  endfunction

  function automatic logic [63:0] red(input int cw);
    return ones_w(cw / 3) << (2 * (cw / 3));
  endfunction

  function automatic logic [63:0] green(input int cw);
    return ones_w(cw / 3) << (cw / 3);
  endfunction

  function automatic logic [63:0] pal_default(input int idx, input int cw);
    case (idx)
      0:       return white(cw);
      1:       return black(cw);
      2:       return red(cw);
      3:       return green(cw);
      default: return black(cw);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/colorizer_layered_blink_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | blink_timer: toggles blink_phase every BLINK_FRAMES frame ticks     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module blink_timer #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/colorizer_layered.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | colorizer_layered: N-layer icon overlay on a palette-mapped world   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module colorizer_layered
  import colorizer_pkg::*;
#(
  parameter int COLOR_W      = 12,
  parameter int WORLD_W      = 2,
  parameter int NUM_LAYERS   = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          video_on,
  input  logic [WORLD_W-1:0]            world,
  input  logic [NUM_LAYERS*COLOR_W-1:0] icons,
  input  logic [NUM_LAYERS-1:0]         blink_en,
  input  logic                          frame_tick,
  input  logic                          pal_we,
  input  logic [WORLD_W-1:0]            pal_addr,
  input  logic [COLOR_W-1:0]            pal_wdata,
  output logic [COLOR_W-1:0]            pal_rdata,
  output logic                          blink_phase,
  output logic [COLOR_W-1:0]            draw_icon
);

  localparam int PAL_DEPTH = 1 << WORLD_W;

  logic [COLOR_W-1:0]            palette_q [PAL_DEPTH];
  logic [COLOR_W-1:0]            palette_d [PAL_DEPTH];
  logic [COLOR_W-1:0]            pal_rdata_q, pal_rdata_d;
  logic                          video_on_s1_q, video_on_s1_d;
  logic [NUM_LAYERS*COLOR_W-1:0] icons_s1_q, icons_s1_d;
  logic [COLOR_W-1:0]            world_col_s1_q, world_col_s1_d;
  logic [NUM_LAYERS-1:0]         vis_s1_q, vis_s1_d;
  logic [COLOR_W-1:0]            draw_icon_q, draw_icon_d;
  logic [COLOR_W-1:0]            layer_col [NUM_LAYERS];

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .blink_phase (blink_phase)
  );

  // World lookup reads palette_q, so a same-edge write is not bypassed.
  always_comb begin
    palette_d = palette_q;
    if (pal_we) palette_d[pal_addr] = pal_wdata;
    pal_rdata_d    = palette_q[pal_addr];
    video_on_s1_d  = video_on;
    icons_s1_d     = icons;
    world_col_s1_d = palette_q[world];
    for (int k = 0; k < NUM_LAYERS; k++) begin
      vis_s1_d[k] = (|icons[k*COLOR_W +: COLOR_W]) & (~blink_en[k] | blink_phase);
    end
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    assign layer_col[k] = icons_s1_q[k*COLOR_W +: COLOR_W];
  end

  // Walk from the bottom layer up so the lowest visible index wins.
  always_comb begin
    draw_icon_d = world_col_s1_q;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (vis_s1_q[k]) draw_icon_d = layer_col[k];
    end
    if (!video_on_s1_q) draw_icon_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        palette_q[i] <= COLOR_W'(pal_default(i, COLOR_W));
      end
      pal_rdata_q    <= '0;
      video_on_s1_q  <= 1'b0;
      icons_s1_q     <= '0;
      world_col_s1_q <= '0;
      vis_s1_q       <= '0;
      draw_icon_q    <= '0;
    end else begin
      palette_q      <= palette_d;
      pal_rdata_q    <= pal_rdata_d;
      video_on_s1_q  <= video_on_s1_d;
      icons_s1_q     <= icons_s1_d;
      world_col_s1_q <= world_col_s1_d;
      vis_s1_q       <= vis_s1_d;
      draw_icon_q    <= draw_icon_d;
    end
  end

  assign pal_rdata = pal_rdata_q;
  assign draw_icon = draw_icon_q;

endmodule
`default_nettype wire

// File: tb/tb_colorizer_layered.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_colorizer_layered: randomized bench with behavioural model       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_colorizer_layered;

  localparam int CW = 12;
  localparam int WW = 2;
  localparam int NL = 2;
  localparam int BF = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           video_on = 1'b0;
  logic [WW-1:0]  world = '0;
  logic [NL*CW-1:0] icons = '0;
  logic [NL-1:0]  blink_en = '0;
  logic           frame_tick = 1'b0;
  logic           pal_we = 1'b0;
  logic [WW-1:0]  pal_addr = '0;
  logic [CW-1:0]  pal_wdata = '0;
  logic [CW-1:0]  pal_rdata;
  logic           blink_phase;
  logic [CW-1:0]  draw_icon;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: palette contents, blink phase and tick count, pixels in flight.
  logic [CW-1:0] m_pal [4];
  logic          m_phase;
  int            m_cnt;
  logic [CW-1:0] m_q [$];

  colorizer_layered #(
    .COLOR_W      (CW),
    .WORLD_W      (WW),
    .NUM_LAYERS   (NL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .video_on    (video_on),
    .world       (world),
    .icons       (icons),
    .blink_en    (blink_en),
    .frame_tick  (frame_tick),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .pal_rdata   (pal_rdata),
    .blink_phase (blink_phase),
    .draw_icon   (draw_icon)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] model_pixel();
    logic [CW-1:0] c;
    if (!video_on) return '0;
    for (int k = 0; k < NL; k++) begin
      c = icons[k*CW +: CW];
      if (c != 0 && (!blink_en[k] || m_phase)) return c;
    end
    return m_pal[world];
  endfunction

  task automatic model_reset();
    m_pal[0] = 12'hFFF;
    m_pal[1] = 12'h000;
    m_pal[2] = 12'hF00;
    m_pal[3] = 12'h0F0;
    m_phase  = 1'b1;
    m_cnt    = 0;
    m_q.delete();
    m_q.push_back('0);
  endtask

  // One clock: inputs already driven; compare all outputs #1 after the edge.
  task automatic step();
    logic [CW-1:0] exp_rd;
    m_q.push_back(model_pixel());
    exp_rd = m_pal[pal_addr];
    @(posedge clk);
    #1;
    if (pal_we) m_pal[pal_addr] = pal_wdata;
    if (frame_tick) begin
      if (m_cnt == BF - 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    chk_eq("draw_icon", 32'(draw_icon), 32'(m_q.pop_front()));
    chk_eq("pal_rdata", 32'(pal_rdata), 32'(exp_rd));
    chk_eq("blink_phase", 32'(blink_phase), 32'(m_phase));
  endtask

  task automatic drive(input logic v, input logic [WW-1:0] w, input logic [CW-1:0] l0,
                       input logic [CW-1:0] l1, input logic [NL-1:0] be, input logic tick);
    video_on   = v;
    world      = w;
    icons      = {l1, l0};
    blink_en   = be;
    frame_tick = tick;
    pal_we     = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk_eq("rst_draw", 32'(draw_icon), 32'h0);
    chk_eq("rst_phase", 32'(blink_phase), 32'h1);
    chk_eq("rst_rdata", 32'(pal_rdata), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // World palette defaults through the pipeline.
    for (int w = 0; w < 4; w++) begin
      drive(1'b1, WW'(w), 12'h000, 12'h000, 2'b00, 1'b0);
      pal_addr = WW'(w);
      step();
    end
    drive(1'b1, 2'd3, 12'h000, 12'h000, 2'b00, 1'b0);
    step();
    chk_eq("t1_green", 32'(draw_icon), 32'h0F0);

    // Layer priority and blanking.
    drive(1'b1, 2'd2, 12'h00F, 12'h0F0, 2'b00, 1'b0); step();
    drive(1'b1, 2'd2, 12'h000, 12'h0F0, 2'b00, 1'b0); step();
    chk_eq("t2_l0", 32'(draw_icon), 32'h00F);
    drive(1'b0, 2'd2, 12'h00F, 12'h0F0, 2'b00, 1'b0); step();
    chk_eq("t2_l1", 32'(draw_icon), 32'h0F0);
    drive(1'b1, 2'd2, 12'h000, 12'h000, 2'b00, 1'b0); step();
    chk_eq("t2_blank", 32'(draw_icon), 32'h000);

    // Palette write: same-edge lookup sees the old entry.
    drive(1'b1, 2'd2, 12'h000, 12'h000, 2'b00, 1'b0);
    pal_we = 1'b1; pal_addr = 2'd2; pal_wdata = 12'h123;
    step();
    pal_we = 1'b0;
    step();
    chk_eq("t3_old", 32'(draw_icon), 32'hF00);
    chk_eq("t3_rdata", 32'(pal_rdata), 32'h123);
    step();
    chk_eq("t3_new", 32'(draw_icon), 32'h123);

    // Blink: two ticks hide layer 0, two more restore it.
    do_reset();
    drive(1'b1, 2'd1, 12'h00F, 12'h000, 2'b01, 1'b1); step(); step();
    frame_tick = 1'b0; step(); step();
    chk_eq("t4_hidden", 32'(draw_icon), 32'h000);
    chk_eq("t4_phase0", 32'(blink_phase), 32'h0);
    frame_tick = 1'b1; step();
    step(); // toggle tick: this pixel still sees phase 0
    frame_tick = 1'b0; step();
    chk_eq("t5_oldphase", 32'(draw_icon), 32'h000);
    step();
    chk_eq("t4_shown", 32'(draw_icon), 32'h00F);

    // Randomized traffic with a reset dropped in the middle.
    for (int n = 0; n < 600; n++) begin
      video_on   = ($urandom_range(0, 7) != 0);
      world      = WW'($urandom);
      icons[0 +: CW]  = ($urandom_range(0, 1) != 0) ? CW'($urandom) : '0;
      icons[CW +: CW] = ($urandom_range(0, 1) != 0) ? CW'($urandom) : '0;
      blink_en   = NL'($urandom);
      frame_tick = ($urandom_range(0, 3) == 0);
      pal_we     = ($urandom_range(0, 9) == 0);
      pal_addr   = WW'($urandom);
      pal_wdata  = CW'($urandom);
      if (n == 300) begin
        step();
        do_reset();
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
